// File: rtl/dmem_ctrl_if.sv
// Request/response bus of the byte-addressed data memory controller.
interface dmem_ctrl_if #(
    parameter int unsigned AW   = 32,
    parameter int unsigned ERRW = 8
);
    logic            req_valid;
    logic            req_ready;
    logic [2:0]      req_op;
    logic [AW-1:0]   req_addr;
    logic [31:0]     req_wdata;
    logic            rsp_valid;
    logic [31:0]     rsp_rdata;
    logic            rsp_err;
    logic [ERRW-1:0] err_count;
    logic            busy_init;

    modport master (
        output req_valid, req_op, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, err_count, busy_init
    );

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, err_count, busy_init
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Byte-wide big-endian data memory with a zeroing sweep after reset,
// single-cycle load latency and a saturating error counter.
module dmem_ctrl #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = 32,
    parameter int unsigned ERRW  = 8
) (
    input  logic        clk,
    input  logic        rst,
    dmem_ctrl_if.slave  bus
);
    localparam int unsigned IW = $clog2(DEPTH);

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SW  = 3'd6;
    localparam logic [2:0] OP_SH  = 3'd7;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_sweep;
    logic [IW-1:0]   w_sweep_nxt;
    logic            r_ready;
    logic            r_busy;
    logic            w_ready_nxt;
    logic            w_busy_nxt;

    logic [7:0]      r_mem [DEPTH];

    logic            r_rsp_valid;
    logic            r_rsp_err;
    logic [31:0]     r_rsp_rdata;
    logic [ERRW-1:0] r_err_count;

    logic            w_accept;
    logic            w_is_store;
    logic            w_is_half;
    logic            w_is_word;
    logic            w_misalign;
    logic            w_oor;
    logic            w_err;
    logic [IW-1:0]   w_idx;
    logic [7:0]      w_b0, w_b1, w_b2, w_b3;
    logic [31:0]     w_ldata;

    // Request decode and error classification
    always_comb begin
        w_accept   = bus.req_valid && r_ready;
        w_is_store = (bus.req_op == OP_SB) || (bus.req_op == OP_SH) || (bus.req_op == OP_SW);
        w_is_half  = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) || (bus.req_op == OP_SH);
        w_is_word  = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
        w_misalign = (w_is_half && bus.req_addr[0]) || (w_is_word && (bus.req_addr[1:0] != 2'b00));
        w_oor      = {1'b0, bus.req_addr} >= (AW+1)'(DEPTH);
        w_err      = w_misalign || w_oor;
        w_idx      = bus.req_addr[IW-1:0];
    end

    // Aligned accesses never carry into higher index bits, so OR selects addr+k
    always_comb begin
        w_b0 = r_mem[w_idx];
        w_b1 = r_mem[w_idx | IW'(1)];
        w_b2 = r_mem[w_idx | IW'(2)];
        w_b3 = r_mem[w_idx | IW'(3)];
        case (bus.req_op)
            OP_LB:   w_ldata = {{24{w_b0[7]}}, w_b0};
            OP_LBU:  w_ldata = {24'h0, w_b0};
            OP_LH:   w_ldata = {{16{w_b0[7]}}, w_b0, w_b1};
            OP_LHU:  w_ldata = {16'h0, w_b0, w_b1};
            OP_LW:   w_ldata = {w_b0, w_b1, w_b2, w_b3};
            default: w_ldata = 32'h0;
        endcase
    end

    // Next-state logic: sweep all bytes once, then serve requests
    always_comb begin
        w_state_nxt = r_state;
        w_sweep_nxt = r_sweep;
        case (r_state)
            ST_CLEAR: begin
                w_sweep_nxt = r_sweep + IW'(1);
                if (r_sweep == IW'(DEPTH - 1)) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_state_nxt = ST_RUN;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
        w_ready_nxt = (w_state_nxt == ST_RUN);
        w_busy_nxt  = (w_state_nxt == ST_CLEAR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_CLEAR;
            r_sweep <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_sweep <= w_sweep_nxt;
            r_ready <= w_ready_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Storage: zeroing sweep, then big-endian stores of good requests
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_sweep] <= 8'h00;
            end else if (w_accept && w_is_store && !w_err) begin
                case (bus.req_op)
                    OP_SB: begin
                        r_mem[w_idx] <= bus.req_wdata[7:0];
                    end
                    OP_SH: begin
                        r_mem[w_idx]          <= bus.req_wdata[15:8];
                        r_mem[w_idx | IW'(1)] <= bus.req_wdata[7:0];
                    end
                    default: begin
                        r_mem[w_idx]          <= bus.req_wdata[31:24];
                        r_mem[w_idx | IW'(1)] <= bus.req_wdata[23:16];
                        r_mem[w_idx | IW'(2)] <= bus.req_wdata[15:8];
                        r_mem[w_idx | IW'(3)] <= bus.req_wdata[7:0];
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'h0;
            r_err_count <= '0;
        end else begin
            r_rsp_valid <= w_accept;
            r_rsp_err   <= w_accept && w_err;
            r_rsp_rdata <= (w_accept && !w_err && !w_is_store) ? w_ldata : 32'h0;
            if (w_accept && w_err && (r_err_count != {ERRW{1'b1}})) begin
                r_err_count <= r_err_count + ERRW'(1);
            end
        end
    end

    assign bus.req_ready = r_ready;
    assign bus.busy_init = r_busy;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.err_count = r_err_count;

endmodule
